// File: rtl/laser_beacon_tracker_if.sv
// Turret pin bundle and published beacon frame between the tracker and its consumer.
// Latency: none (wiring only).
// Backpressure: none; pins are free-running and the frame is a level-held snapshot plus a one-cycle strobe.
// Optional: BEACON_CENTER_EN adds the beacon_center frame field.
interface laser_beacon_tracker_if #(
  parameter int POS_W     = 16,
  parameter int N_BEACONS = 4
);
  logic                               laser_signal;
  logic                               laser_sync;
  logic                               laser_cod_a;
  logic                               laser_cod_b;
  logic [POS_W-1:0]                   position;
  logic                               position_direction;
  logic                               beacon_detection;
  logic [N_BEACONS*POS_W-1:0]         beacon_rising;
  logic [N_BEACONS*POS_W-1:0]         beacon_falling;
  logic [$clog2(N_BEACONS+1)-1:0]     beacon_count;
  logic                               frame_overflow;
  logic                               frame_valid;
`ifdef BEACON_CENTER_EN
  logic [N_BEACONS*POS_W-1:0]         beacon_center;
`endif

  // Tracker side: samples the pins, drives the frame.
  modport master (
    input  laser_signal, laser_sync, laser_cod_a, laser_cod_b,
    output position, position_direction, beacon_detection,
           beacon_rising, beacon_falling, beacon_count, frame_overflow, frame_valid
`ifdef BEACON_CENTER_EN
    , output beacon_center
`endif
  );

  // Consumer side: drives the pins, reads the frame.
  modport slave (
    output laser_signal, laser_sync, laser_cod_a, laser_cod_b,
    input  position, position_direction, beacon_detection,
           beacon_rising, beacon_falling, beacon_count, frame_overflow, frame_valid
`ifdef BEACON_CENTER_EN
    , input beacon_center
`endif
  );
endinterface

// File: rtl/laser_beacon_tracker.sv
// Tracks turret angle from a quadrature encoder and captures laser beacon edge pairs per revolution.
// Latency: SYNC_STAGES+1 cycles from pin change to position/capture; frame published 1 cycle after the sync edge.
// Backpressure: none; frames are overwritten at every index pulse, extra beacons set frame_overflow.
// Optional: BEACON_CENTER_EN adds per-beacon centre positions to the published frame.
module laser_beacon_tracker #(
  parameter int POS_W       = 16,
  parameter int N_BEACONS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 2
) (
  input  logic clk,
  input  logic rst_n,
  laser_beacon_tracker_if.master bus
);
  localparam int CNT_W = $clog2(N_BEACONS+1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, IN_BEACON = 2'd2} state_t;

  // Bit order for the synchroniser bank: 0 = B, 1 = A, 2 = sync, 3 = laser.
  logic [3:0]                   w_in;
  logic [3:0][SYNC_STAGES-1:0]  r_sync;
  logic [3:0]                   w_s;
  logic [3:0]                   r_dly;

  logic w_b_rise, w_a, w_sync_rise, w_laser, w_laser_fall, w_laser_rise;

  logic [POS_W-1:0] r_position;
  logic             r_direction;
  logic             r_detect;

  state_t           r_state;
  logic [POS_W-1:0] r_rise_tmp;
  logic [CNT_W-1:0] r_idx;
  logic             r_ovf;
  logic [N_BEACONS-1:0][POS_W-1:0] r_work_rise;
  logic [N_BEACONS-1:0][POS_W-1:0] r_work_fall;
  logic [N_BEACONS-1:0][POS_W-1:0] r_pub_rise;
  logic [N_BEACONS-1:0][POS_W-1:0] r_pub_fall;
  logic [CNT_W-1:0] r_pub_count;
  logic             r_pub_ovf;
  logic             r_frame_valid;
`ifdef BEACON_CENTER_EN
  logic [N_BEACONS-1:0][POS_W-1:0] r_work_ctr;
  logic [N_BEACONS-1:0][POS_W-1:0] r_pub_ctr;
  logic [POS_W-1:0] w_center;
`endif

  // Values as seen after the sync edge of this cycle has been applied; laser edges act on these.
  logic             w_pub;
  state_t           w_st_eff;
  logic [POS_W-1:0] w_pos_eff;
  logic [POS_W-1:0] w_rise_eff;
  logic [CNT_W-1:0] w_idx_eff;
  logic             w_ovf_eff;
  logic [POS_W-1:0] w_width;
  logic             w_open, w_close, w_keep, w_wr, w_ovf_set;

  assign w_in = {bus.laser_signal, bus.laser_sync, bus.laser_cod_a, bus.laser_cod_b};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_last
      assign w_s[g] = r_sync[g][SYNC_STAGES-1];
    end
  endgenerate

  assign w_b_rise     = w_s[0] & ~r_dly[0];
  assign w_a          = w_s[1];
  assign w_sync_rise  = w_s[2] & ~r_dly[2];
  assign w_laser      = w_s[3];
  assign w_laser_fall = ~w_s[3] &  r_dly[3];
  assign w_laser_rise =  w_s[3] & ~r_dly[3];

  // Synchroniser chains, one extra delayed copy for edge detection, and the beacon-in-view flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_dly    <= '0;
      r_detect <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_in[k]};
      r_dly    <= w_s;
      r_detect <= ~w_laser;
    end
  end

  // Encoder counter: counts on B rising, index pulse zeroes it and wins over a coincident count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_position  <= '0;
      r_direction <= 1'b0;
    end else begin
      if (w_b_rise) r_direction <= w_a;
      if (w_sync_rise)   r_position <= '0;
      else if (w_b_rise) r_position <= w_a ? r_position + 1'b1 : r_position - 1'b1;
    end
  end

  // Resolve the sync edge first so a same-cycle laser edge lands in the new frame at position 0.
  always_comb begin
    w_pub      = w_sync_rise && (r_state != IDLE);
    w_pos_eff  = w_sync_rise ? '0 : r_position;
    w_rise_eff = w_sync_rise ? '0 : r_rise_tmp;
    w_idx_eff  = w_pub ? '0 : r_idx;
    w_ovf_eff  = w_pub ? 1'b0 : r_ovf;
    w_st_eff   = r_state;
    if (r_state == IDLE && w_sync_rise) w_st_eff = w_laser ? SEARCH : IN_BEACON;
    w_width    = w_pos_eff - w_rise_eff;
    w_open     = (w_st_eff == SEARCH) && w_laser_fall;
    w_close    = (w_st_eff == IN_BEACON) && w_laser_rise;
    w_keep     = w_close && (w_width >= POS_W'(MIN_WIDTH));
    w_wr       = w_keep && (w_idx_eff < CNT_W'(N_BEACONS));
    w_ovf_set  = w_keep && !(w_idx_eff < CNT_W'(N_BEACONS));
  end

`ifdef BEACON_CENTER_EN
  assign w_center = w_rise_eff + (w_width >> 1);
`endif

  // Beacon FSM, working buffer capture and atomic frame publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rise_tmp    <= '0;
      r_idx         <= '0;
      r_ovf         <= 1'b0;
      r_work_rise   <= '0;
      r_work_fall   <= '0;
      r_pub_rise    <= '0;
      r_pub_fall    <= '0;
      r_pub_count   <= '0;
      r_pub_ovf     <= 1'b0;
      r_frame_valid <= 1'b0;
`ifdef BEACON_CENTER_EN
      r_work_ctr    <= '0;
      r_pub_ctr     <= '0;
`endif
    end else begin
      r_frame_valid <= w_pub;
      if (w_pub) begin
        r_pub_rise  <= r_work_rise;
        r_pub_fall  <= r_work_fall;
        r_pub_count <= r_idx;
        r_pub_ovf   <= r_ovf;
        r_work_rise <= '0;
        r_work_fall <= '0;
`ifdef BEACON_CENTER_EN
        r_pub_ctr   <= r_work_ctr;
        r_work_ctr  <= '0;
`endif
      end

      if (w_close)     r_state <= SEARCH;
      else if (w_open) r_state <= IN_BEACON;
      else             r_state <= w_st_eff;

      if (w_open)           r_rise_tmp <= w_pos_eff;
      else if (w_sync_rise) r_rise_tmp <= '0;

      r_idx <= w_wr ? w_idx_eff + 1'b1 : w_idx_eff;
      r_ovf <= w_ovf_eff | w_ovf_set;

      for (int i = 0; i < N_BEACONS; i++) begin
        if (w_wr && w_idx_eff == CNT_W'(i)) begin
          r_work_rise[i] <= w_rise_eff;
          r_work_fall[i] <= w_pos_eff;
`ifdef BEACON_CENTER_EN
          r_work_ctr[i]  <= w_center;
`endif
        end
      end
    end
  end

  assign bus.position           = r_position;
  assign bus.position_direction = r_direction;
  assign bus.beacon_detection   = r_detect;
  assign bus.beacon_rising      = r_pub_rise;
  assign bus.beacon_falling     = r_pub_fall;
  assign bus.beacon_count       = r_pub_count;
  assign bus.frame_overflow     = r_pub_ovf;
  assign bus.frame_valid        = r_frame_valid;
`ifdef BEACON_CENTER_EN
  assign bus.beacon_center      = r_pub_ctr;
`endif
endmodule

// File: tb/tb_laser_beacon_tracker.sv
// Directed bench for laser_beacon_tracker: pins driven on the falling edge, outputs sampled there too.
// Each scenario task carries its own hand-computed expectations.
// Optional: BEACON_CENTER_EN enables the centre checks.
module tb_laser_beacon_tracker;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  laser_beacon_tracker_if #(.POS_W(16), .N_BEACONS(4)) bus ();

  laser_beacon_tracker #(
    .POS_W(16), .N_BEACONS(4), .SYNC_STAGES(2), .MIN_WIDTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n encoder counts in the direction given by a.
  task automatic pulse_b(input logic a, input int n);
    bus.laser_cod_a = a;
    tick(3);
    for (int i = 0; i < n; i++) begin
      bus.laser_cod_b = 1'b1; tick(2);
      bus.laser_cod_b = 1'b0; tick(2);
    end
    tick(3);
  endtask

  task automatic set_laser(input logic v);
    bus.laser_signal = v;
    tick(4);
  endtask

  // Index pulse; returns how many sampled cycles had frame_valid high.
  task automatic do_sync(output int fv_cnt);
    fv_cnt = 0;
    bus.laser_sync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.frame_valid === 1'b1) fv_cnt++;
    end
    bus.laser_sync = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.laser_signal = 1'b1; bus.laser_sync = 1'b0;
    bus.laser_cod_a = 1'b0;  bus.laser_cod_b = 1'b0;
    tick(3);
    n_vec++; if (bus.position !== 16'd0) begin n_err++; $display("FAIL reset_pos: got %0h want 0", bus.position); end
    n_vec++; if (bus.frame_valid !== 1'b0 || bus.beacon_count !== 3'd0 || bus.frame_overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_frame: fv %b cnt %0d ovf %b want 0", bus.frame_valid, bus.beacon_count, bus.frame_overflow); end
    n_vec++; if (bus.beacon_rising !== 64'd0 || bus.beacon_falling !== 64'd0) begin
      n_err++; $display("FAIL reset_slots: rise %0h fall %0h want 0", bus.beacon_rising, bus.beacon_falling); end
    rst_n = 1'b1;
    tick(2);
    pulse_b(1'b1, 37);
    n_vec++; if (bus.position !== 16'd37) begin n_err++; $display("FAIL pre_reset_pos: got %0d want 37", bus.position); end
    set_laser(1'b0);
    n_vec++; if (bus.beacon_detection !== 1'b1) begin n_err++; $display("FAIL detect_low: got %b want 1", bus.beacon_detection); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.position !== 16'd0 || bus.position_direction !== 1'b0 || bus.beacon_detection !== 1'b0) begin
      n_err++; $display("FAIL async_reset: pos %0d dir %b det %b want 0", bus.position, bus.position_direction, bus.beacon_detection); end
    bus.laser_signal = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    n_vec++; if (bus.position !== 16'd0 || bus.beacon_detection !== 1'b0) begin
      n_err++; $display("FAIL post_reset: pos %0d det %b want 0", bus.position, bus.beacon_detection); end
  endtask

  task automatic test_up_down;
    pulse_b(1'b1, 10);
    n_vec++; if (bus.position !== 16'd10 || bus.position_direction !== 1'b1) begin
      n_err++; $display("FAIL count_up: pos %0d dir %b want 10 1", bus.position, bus.position_direction); end
    pulse_b(1'b0, 12);
    n_vec++; if (bus.position !== 16'hFFFE || bus.position_direction !== 1'b0) begin
      n_err++; $display("FAIL count_down: pos %0h dir %b want fffe 0", bus.position, bus.position_direction); end
  endtask

  task automatic test_first_sync;
    int fv;
    do_sync(fv);
    n_vec++; if (fv !== 0) begin n_err++; $display("FAIL first_sync_fv: got %0d cycles want 0", fv); end
    n_vec++; if (bus.position !== 16'd0) begin n_err++; $display("FAIL first_sync_pos: got %0h want 0", bus.position); end
  endtask

  task automatic test_two_beacons;
    int fv;
    logic [15:0] er [4] = '{16'd100, 16'd300, 16'd0, 16'd0};
    logic [15:0] ef [4] = '{16'd120, 16'd340, 16'd0, 16'd0};
    logic [15:0] ec [4] = '{16'd110, 16'd320, 16'd0, 16'd0};
    pulse_b(1'b1, 100); set_laser(1'b0);
    pulse_b(1'b1, 20);  set_laser(1'b1);
    pulse_b(1'b1, 180); set_laser(1'b0);
    pulse_b(1'b1, 40);  set_laser(1'b1);
    do_sync(fv);
    n_vec++; if (fv !== 1) begin n_err++; $display("FAIL two_fv: got %0d cycles want 1", fv); end
    n_vec++; if (bus.beacon_count !== 3'd2 || bus.frame_overflow !== 1'b0) begin
      n_err++; $display("FAIL two_count: cnt %0d ovf %b want 2 0", bus.beacon_count, bus.frame_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.beacon_rising[i*16 +: 16] !== er[i] || bus.beacon_falling[i*16 +: 16] !== ef[i]) begin
        n_err++; $display("FAIL two_slot%0d: rise %0d fall %0d want %0d %0d", i,
          bus.beacon_rising[i*16 +: 16], bus.beacon_falling[i*16 +: 16], er[i], ef[i]); end
`ifdef BEACON_CENTER_EN
      n_vec++; if (bus.beacon_center[i*16 +: 16] !== ec[i]) begin
        n_err++; $display("FAIL two_center%0d: got %0d want %0d", i, bus.beacon_center[i*16 +: 16], ec[i]); end
`endif
    end
    if (ec[0] === 16'hxxxx) $display("center table unset");
  endtask

  task automatic test_glitch_overflow;
    int fv;
    pulse_b(1'b1, 2); set_laser(1'b0);
    pulse_b(1'b1, 1); set_laser(1'b1);
    for (int k = 0; k < 5; k++) begin
      pulse_b(1'b1, 2); set_laser(1'b0);
      pulse_b(1'b1, 2); set_laser(1'b1);
    end
    do_sync(fv);
    n_vec++; if (fv !== 1) begin n_err++; $display("FAIL ovf_fv: got %0d cycles want 1", fv); end
    n_vec++; if (bus.beacon_count !== 3'd4 || bus.frame_overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_count: cnt %0d ovf %b want 4 1", bus.beacon_count, bus.frame_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.beacon_rising[i*16 +: 16] !== 16'(5 + 4*i) || bus.beacon_falling[i*16 +: 16] !== 16'(7 + 4*i)) begin
        n_err++; $display("FAIL ovf_slot%0d: rise %0d fall %0d want %0d %0d", i,
          bus.beacon_rising[i*16 +: 16], bus.beacon_falling[i*16 +: 16], 5 + 4*i, 7 + 4*i); end
`ifdef BEACON_CENTER_EN
      n_vec++; if (bus.beacon_center[i*16 +: 16] !== 16'(6 + 4*i)) begin
        n_err++; $display("FAIL ovf_center%0d: got %0d want %0d", i, bus.beacon_center[i*16 +: 16], 6 + 4*i); end
`endif
    end
  endtask

  task automatic test_simultaneous;
    int fv;
    pulse_b(1'b1, 3); set_laser(1'b0);
    pulse_b(1'b1, 1);
    bus.laser_cod_a = 1'b0;
    tick(3);
    fv = 0;
    bus.laser_sync = 1'b1; bus.laser_cod_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.frame_valid === 1'b1) fv++;
    end
    bus.laser_sync = 1'b0; bus.laser_cod_b = 1'b0;
    tick(4);
    n_vec++; if (bus.position !== 16'd0 || bus.position_direction !== 1'b0) begin
      n_err++; $display("FAIL sync_b_same: pos %0h dir %b want 0 0", bus.position, bus.position_direction); end
    n_vec++; if (fv !== 1 || bus.beacon_count !== 3'd0 || bus.frame_overflow !== 1'b0 || bus.beacon_rising !== 64'd0) begin
      n_err++; $display("FAIL span_old_frame: fv %0d cnt %0d ovf %b rise %0h want 1 0 0 0", fv,
        bus.beacon_count, bus.frame_overflow, bus.beacon_rising); end
    pulse_b(1'b1, 6); set_laser(1'b1);
    do_sync(fv);
    n_vec++; if (fv !== 1 || bus.beacon_count !== 3'd1) begin
      n_err++; $display("FAIL span_new_count: fv %0d cnt %0d want 1 1", fv, bus.beacon_count); end
    n_vec++; if (bus.beacon_rising[15:0] !== 16'd0 || bus.beacon_falling[15:0] !== 16'd6) begin
      n_err++; $display("FAIL span_new_slot: rise %0d fall %0d want 0 6", bus.beacon_rising[15:0], bus.beacon_falling[15:0]); end
`ifdef BEACON_CENTER_EN
    n_vec++; if (bus.beacon_center[15:0] !== 16'd3) begin
      n_err++; $display("FAIL span_center: got %0d want 3", bus.beacon_center[15:0]); end
`endif
  endtask

  task automatic test_wrap;
    int fv;
    pulse_b(1'b1, 2); set_laser(1'b0);
    pulse_b(1'b0, 4);
    n_vec++; if (bus.position !== 16'hFFFE) begin n_err++; $display("FAIL wrap_pos: got %0h want fffe", bus.position); end
    set_laser(1'b1);
    do_sync(fv);
    n_vec++; if (fv !== 1 || bus.beacon_count !== 3'd1 || bus.frame_overflow !== 1'b0) begin
      n_err++; $display("FAIL wrap_count: fv %0d cnt %0d ovf %b want 1 1 0", fv, bus.beacon_count, bus.frame_overflow); end
    n_vec++; if (bus.beacon_rising[15:0] !== 16'd2 || bus.beacon_falling[15:0] !== 16'hFFFE) begin
      n_err++; $display("FAIL wrap_slot: rise %0h fall %0h want 2 fffe", bus.beacon_rising[15:0], bus.beacon_falling[15:0]); end
`ifdef BEACON_CENTER_EN
    n_vec++; if (bus.beacon_center[15:0] !== 16'h8000) begin
      n_err++; $display("FAIL wrap_center: got %0h want 8000", bus.beacon_center[15:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_first_sync();
    test_two_beacons();
    test_glitch_overflow();
    test_simultaneous();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
